// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file slave.
package i2c_pkg;

    localparam int ADDR_BITS = 7;
    localparam int BYTE_BITS = 8;

    localparam logic [ADDR_BITS-1:0] GENERAL_CALL_ADDR = 7'h00;
    localparam logic                 I2C_RW_WRITE      = 1'b0;
    localparam logic                 I2C_RW_READ       = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with one-CLK SCL edge and START/STOP condition pulses.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_prev;
    logic                   sda_prev;

    // Idle bus level is high on both lines, so reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave with auto-incrementing byte register file and host access port.
// Optional general-call write support is enabled by defining I2C_GENERAL_CALL_EN.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [ADDR_BITS-1:0] ADDRESS     = 7'h26,
    parameter int                   DEPTH       = 16,
    parameter int                   SYNC_STAGES = 2,
    localparam int                  PTR_W       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scl,
    input  logic                 sda_in,
    output logic                 sda_oe,
    input  logic                 host_we,
    input  logic [PTR_W-1:0]     host_addr,
    input  logic [BYTE_BITS-1:0] host_wdata,
    output logic [BYTE_BITS-1:0] host_rdata,
    output logic                 wr_valid,
    output logic [PTR_W-1:0]     wr_addr,
    output logic [BYTE_BITS-1:0] wr_data,
    output logic                 busy,
    output logic                 gc_hit
);

`ifdef I2C_GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_in    (sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t           state;
    logic [3:0]           bit_cnt;
    logic [BYTE_BITS-1:0] shreg;
    logic [PTR_W-1:0]     ptr;
    logic                 rw_read;
    logic                 is_gc;
    logic [BYTE_BITS-1:0] regs [DEPTH];

    logic [BYTE_BITS-1:0] byte_in;
    logic                 byte_done;
    logic                 addr_hit;
    logic                 gc_match;
    logic                 i2c_we;

    assign byte_in   = {shreg[BYTE_BITS-2:0], sda_s};
    assign byte_done = scl_rise && (bit_cnt == 4'd7);
    assign addr_hit  = (byte_in[BYTE_BITS-1:1] == ADDRESS);
    assign gc_match  = GC_EN && (byte_in[BYTE_BITS-1:1] == GENERAL_CALL_ADDR)
                       && (byte_in[0] == I2C_RW_WRITE);
    assign i2c_we    = (state == ST_WDATA) && byte_done && !start_det && !stop_det;

    // NOTE: the register file has a defined reset value, so every entry is a flop with reset.
    // The I2C write is placed last so it wins a same-cycle collision with the host.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (host_we) regs[host_addr] <= host_wdata;
            if (i2c_we)  regs[ptr]       <= byte_in;
        end
    end

    assign host_rdata = regs[host_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            rw_read  <= 1'b0;
            is_gc    <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            gc_hit   <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            gc_hit   <= 1'b0;
            if (stop_det) begin
                state   <= ST_IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WDATA: if (scl_rise) begin
                        shreg   <= byte_in;
                        bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
                        if (byte_done) begin
                            if (state == ST_ADDR) begin
                                rw_read <= (byte_in[0] == I2C_RW_READ);
                                is_gc   <= gc_match;
                                busy    <= addr_hit || gc_match;
                                state   <= (addr_hit || gc_match) ? ST_ADDR_ACK : ST_IGNORE;
                            end else if (state == ST_PTR) begin
                                ptr   <= byte_in[PTR_W-1:0];
                                state <= ST_PTR_ACK;
                            end else begin
                                wr_valid <= 1'b1;
                                wr_addr  <= ptr;
                                wr_data  <= byte_in;
                                ptr      <= ptr + PTR_W'(1);
                                state    <= ST_WDATA_ACK;
                            end
                        end
                    end
                    // First SCL fall drives the ACK, the second ends it and starts the next byte.
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                            gc_hit <= is_gc;
                        end else if (rw_read) begin
                            shreg  <= regs[ptr];
                            sda_oe <= ~regs[ptr][BYTE_BITS-1];
                            state  <= ST_RDATA;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= ST_PTR;
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                        sda_oe <= !sda_oe;
                        if (sda_oe) state <= ST_WDATA;
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                ptr     <= ptr + PTR_W'(1);
                                state   <= ST_RACK;
                            end else begin
                                shreg  <= shreg << 1;
                                sda_oe <= ~shreg[BYTE_BITS-2];
                            end
                        end
                    end
                    ST_RACK: begin
                        if (scl_rise && sda_s) begin
                            state <= ST_IGNORE;
                            busy  <= 1'b0;
                        end else if (scl_fall) begin
                            shreg  <= regs[ptr];
                            sda_oe <= ~regs[ptr][BYTE_BITS-1];
                            state  <= ST_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Self-checking bench for i2c_slave_regs: bit-banged I2C master plus a register-file model.
// Expectations for the general-call case follow whether I2C_GENERAL_CALL_EN is defined.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

    localparam int         DEPTH = 16;
    localparam int         Q     = 6;
    localparam logic [6:0] SADDR = 7'h26;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       master_low = 1'b0;
    logic       sda_line;
    logic       sda_oe;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic [7:0] host_rdata;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       gc_hit;

    // Open-drain bus with pull-up: low if either side pulls.
    assign sda_line = ~(sda_oe | master_low);

    i2c_slave_regs #(.ADDRESS(SADDR), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl        (scl),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .gc_hit     (gc_hit)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the register file and the auto-incrementing pointer.
    logic [7:0] mem [DEPTH];
    int         mptr = 0;

    logic [7:0]  wbuf [8];
    logic [7:0]  rbuf [8];
    logic [7:0]  expb [8];
    logic [11:0] wr_q [$];
    int          gc_count = 0;
    int          wr_long = 0;
    bit          oe_seen = 0;
    bit          busy_seen = 0;
    logic        wr_prev = 1'b0;
    bit          hw_pending = 0;
    logic [3:0]  hw_addr = '0;
    logic [7:0]  hw_data = '0;

    always @(negedge clk) begin
        if (wr_valid) wr_q.push_back({wr_addr, wr_data});
        if (wr_valid && wr_prev) wr_long++;
        wr_prev = wr_valid;
        if (gc_hit) gc_count++;
        if (sda_oe) oe_seen = 1;
        if (busy) busy_seen = 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- bus primitives ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        master_low = 1'b0; tick(Q);
        scl = 1'b1;        tick(Q);
        master_low = 1'b1; tick(Q);
        scl = 1'b0;        tick(Q);
    endtask

    task automatic bus_stop();
        master_low = 1'b1; tick(Q);
        scl = 1'b1;        tick(Q);
        master_low = 1'b0; tick(2 * Q);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        master_low = ~b; tick(Q);
        scl = 1'b1;      tick(Q);
        @(negedge clk) r = sda_line;
        tick(Q);
        scl = 1'b0;      tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
        bus_bit(1'b1, r);
        ack = ~r;
    endtask

    // Last data bit is sent while the host hammers the same register with ~d.
    task automatic send_byte_collide(input logic [7:0] d, input logic [3:0] ca,
                                     output logic ack, output bit seen);
        logic r;
        seen = 0;
        for (int i = 7; i >= 1; i--) bus_bit(d[i], r);
        master_low = ~d[0]; tick(Q);
        host_addr = ca; host_wdata = ~d; host_we = 1'b1;
        scl = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (wr_valid) seen = 1;
        end
        host_we = 1'b0;
        tick(Q);
        scl = 1'b0; tick(Q);
        bus_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input bit mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
            if (i == 4 && hw_pending) begin
                host_addr = hw_addr; host_wdata = hw_data; host_we = 1'b1;
                tick(1);
                host_we = 1'b0;
                hw_pending = 0;
            end
        end
        bus_bit(~mack, r);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
    endtask

    task automatic write_txn(input logic [6:0] a, input logic [7:0] p, input int n,
                             output logic all_ack);
        logic k;
        all_ack = 1'b1;
        bus_start();
        send_byte({a, 1'b0}, k); all_ack &= k;
        send_byte(p, k);         all_ack &= k;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], k); all_ack &= k;
        end
        bus_stop();
    endtask

    task automatic read_txn(input bit set_ptr, input logic [7:0] p, input int n,
                            output logic all_ack, output logic busy_after);
        logic k;
        logic [7:0] d;
        all_ack = 1'b1;
        bus_start();
        if (set_ptr) begin
            send_byte({SADDR, 1'b0}, k); all_ack &= k;
            send_byte(p, k);             all_ack &= k;
            bus_start();
        end
        send_byte({SADDR, 1'b1}, k); all_ack &= k;
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, d);
            rbuf[i] = d;
        end
        busy_after = busy;
        bus_stop();
    endtask

    // Model: pointer byte is taken mod DEPTH, each data byte advances the pointer.
    function automatic void model_write(input logic [7:0] p, input int n);
        mptr = int'(p) % DEPTH;
        for (int i = 0; i < n; i++) begin
            mem[mptr] = wbuf[i];
            mptr = (mptr + 1) % DEPTH;
        end
    endfunction

    function automatic void model_read(input bit set_ptr, input logic [7:0] p, input int n);
        if (set_ptr) mptr = int'(p) % DEPTH;
        for (int i = 0; i < n; i++) begin
            expb[i] = mem[mptr];
            mptr = (mptr + 1) % DEPTH;
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        n_tests++;
        if ({sda_oe, busy, wr_valid, gc_hit} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: sda_oe/busy/wr_valid/gc_hit=%b expected 0000",
                     {sda_oe, busy, wr_valid, gc_hit});
        end
        n_tests++;
        if ({wr_addr, wr_data} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_wr_bus: got %h expected 000", {wr_addr, wr_data});
        end
        for (int i = 0; i < DEPTH; i++) begin
            host_addr = 4'(i); #1;
            n_tests++;
            if (host_rdata !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_reg[%0d]: got %h expected 00", i, host_rdata);
            end
        end
    endtask

    task automatic test_basic_write();
        logic ack;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        wr_q.delete(); wr_long = 0;
        write_txn(SADDR, 8'h03, 2, ack);
        model_write(8'h03, 2);
        n_tests++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL basic_write_ack: got %b expected 1", ack); end
        n_tests++;
        if (wr_q.size() != 2) begin
            n_fail++; $display("FAIL basic_write_count: got %0d expected 2", wr_q.size());
        end else begin
            n_tests++;
            if (wr_q[0] !== 12'h3A5) begin n_fail++; $display("FAIL basic_wr0: got %h expected 3a5", wr_q[0]); end
            n_tests++;
            if (wr_q[1] !== 12'h45A) begin n_fail++; $display("FAIL basic_wr1: got %h expected 45a", wr_q[1]); end
        end
        n_tests++;
        if (wr_long != 0) begin n_fail++; $display("FAIL wr_valid_width: got %0d long pulses expected 0", wr_long); end
        host_addr = 4'd3; #1;
        n_tests++;
        if (host_rdata !== 8'hA5) begin n_fail++; $display("FAIL basic_host_rd3: got %h expected a5", host_rdata); end
    endtask

    task automatic test_repeated_start_read();
        logic ack, bz;
        for (int i = 2; i <= 4; i++) begin
            mem[i] = 8'($urandom);
            host_write(4'(i), mem[i]);
        end
        model_read(1, 8'h02, 3);
        read_txn(1, 8'h02, 3, ack, bz);
        n_tests++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL rs_read_ack: got %b expected 1", ack); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (rbuf[i] !== expb[i]) begin
                n_fail++; $display("FAIL rs_read_byte%0d: got %h expected %h", i, rbuf[i], expb[i]);
            end
        end
        n_tests++;
        if (bz !== 1'b0) begin n_fail++; $display("FAIL rs_busy_after_nack: got %b expected 0", bz); end
        // Pointer retained (should be 5): read one byte without a pointer write.
        model_read(0, 8'h00, 1);
        read_txn(0, 8'h00, 1, ack, bz);
        n_tests++;
        if (rbuf[0] !== expb[0]) begin
            n_fail++; $display("FAIL ptr_retained: got %h expected %h", rbuf[0], expb[0]);
        end
    endtask

    task automatic test_wrap();
        logic ack;
        for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
        wr_q.delete();
        write_txn(SADDR, 8'h0F, 3, ack);
        model_write(8'h0F, 3);
        n_tests++;
        if (wr_q.size() != 3) begin
            n_fail++; $display("FAIL wrap_count: got %0d expected 3", wr_q.size());
        end else begin
            n_tests++;
            if (wr_q[0] !== {4'd15, wbuf[0]}) begin n_fail++; $display("FAIL wrap_wr0: got %h expected %h", wr_q[0], {4'd15, wbuf[0]}); end
            n_tests++;
            if (wr_q[1] !== {4'd0, wbuf[1]})  begin n_fail++; $display("FAIL wrap_wr1: got %h expected %h", wr_q[1], {4'd0, wbuf[1]}); end
            n_tests++;
            if (wr_q[2] !== {4'd1, wbuf[2]})  begin n_fail++; $display("FAIL wrap_wr2: got %h expected %h", wr_q[2], {4'd1, wbuf[2]}); end
        end
        host_addr = 4'd0; #1;
        n_tests++;
        if (host_rdata !== mem[0]) begin n_fail++; $display("FAIL wrap_reg0: got %h expected %h", host_rdata, mem[0]); end
    endtask

    task automatic test_nomatch();
        logic ack;
        logic [6:0] a;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) a = 7'h27;
            else begin
                do a = 7'($urandom); while (a == SADDR || a == 7'h00);
            end
            wbuf[0] = 8'($urandom);
            wr_q.delete(); oe_seen = 0; busy_seen = 0;
            write_txn(a, 8'($urandom), 1, ack);
            n_tests++;
            if (ack !== 1'b0) begin n_fail++; $display("FAIL nomatch_ack addr %h: got %b expected 0", a, ack); end
            n_tests++;
            if (oe_seen || busy_seen || wr_q.size() != 0) begin
                n_fail++;
                $display("FAIL nomatch_quiet addr %h: oe=%0d busy=%0d writes=%0d expected 0/0/0",
                         a, oe_seen, busy_seen, wr_q.size());
            end
        end
    endtask

    task automatic test_host();
        logic [3:0] a;
        logic [7:0] d;
        for (int it = 0; it < 8; it++) begin
            a = 4'($urandom); d = 8'($urandom);
            host_write(a, d);
            mem[a] = d;
            n_tests++;
            if (host_rdata !== d) begin n_fail++; $display("FAIL host_rw[%0d]: got %h expected %h", a, host_rdata, d); end
        end
    endtask

    task automatic test_random();
        logic ack, bz;
        logic [7:0] p;
        int n, q;
        bit sp;
        for (int it = 0; it < 6; it++) begin
            p = 8'($urandom); n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            wr_q.delete();
            write_txn(SADDR, p, n, ack);
            q = int'(p) % DEPTH;
            n_tests++;
            if (ack !== 1'b1) begin n_fail++; $display("FAIL rnd_write_ack it%0d: got %b expected 1", it, ack); end
            n_tests++;
            if (wr_q.size() != n) begin
                n_fail++; $display("FAIL rnd_write_count it%0d: got %0d expected %0d", it, wr_q.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    n_tests++;
                    if (wr_q[i] !== {4'((q + i) % DEPTH), wbuf[i]}) begin
                        n_fail++; $display("FAIL rnd_wr it%0d.%0d: got %h expected %h",
                                           it, i, wr_q[i], {4'((q + i) % DEPTH), wbuf[i]});
                    end
                end
            end
            model_write(p, n);

            sp = 1'($urandom); p = 8'($urandom); n = $urandom_range(1, 4);
            model_read(sp, p, n);
            read_txn(sp, p, n, ack, bz);
            n_tests++;
            if (ack !== 1'b1) begin n_fail++; $display("FAIL rnd_read_ack it%0d: got %b expected 1", it, ack); end
            for (int i = 0; i < n; i++) begin
                n_tests++;
                if (rbuf[i] !== expb[i]) begin
                    n_fail++; $display("FAIL rnd_read it%0d.%0d: got %h expected %h", it, i, rbuf[i], expb[i]);
                end
            end
        end
    endtask

    task automatic test_host_during_read();
        logic ack, bz;
        logic [7:0] p, newv;
        p = 8'($urandom_range(0, DEPTH - 1));
        mem[p[3:0]] = 8'($urandom);
        host_write(p[3:0], mem[p[3:0]]);
        newv = ~mem[p[3:0]];
        model_read(1, p, 1);
        hw_pending = 1; hw_addr = p[3:0]; hw_data = newv;
        read_txn(1, p, 1, ack, bz);
        mem[p[3:0]] = newv;
        n_tests++;
        if (rbuf[0] !== expb[0]) begin n_fail++; $display("FAIL tx_byte_frozen: got %h expected %h", rbuf[0], expb[0]); end
        host_addr = p[3:0]; #1;
        n_tests++;
        if (host_rdata !== newv) begin n_fail++; $display("FAIL tx_host_write: got %h expected %h", host_rdata, newv); end
    endtask

    task automatic test_collision();
        logic k, ack;
        bit seen;
        logic [3:0] p;
        logic [7:0] d;
        p = 4'($urandom); d = 8'($urandom);
        ack = 1'b1;
        bus_start();
        send_byte({SADDR, 1'b0}, k); ack &= k;
        send_byte({4'h0, p}, k);     ack &= k;
        send_byte_collide(d, p, k, seen); ack &= k;
        bus_stop();
        mem[p] = d; mptr = (int'(p) + 1) % DEPTH;
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL collide_wr_valid: got none expected pulse within 40 cycles"); end
        n_tests++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL collide_ack: got %b expected 1", ack); end
        host_addr = p; #1;
        n_tests++;
        if (host_rdata !== d) begin n_fail++; $display("FAIL collide_i2c_wins: got %h expected %h", host_rdata, d); end
    endtask

    task automatic test_general_call();
        logic ack;
        wbuf[0] = 8'h77;
        wr_q.delete(); gc_count = 0;
        write_txn(7'h00, 8'h01, 1, ack);
`ifdef I2C_GENERAL_CALL_EN
        model_write(8'h01, 1);
        n_tests++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL gc_ack: got %b expected 1", ack); end
        n_tests++;
        if (gc_count != 1) begin n_fail++; $display("FAIL gc_hit_count: got %0d expected 1", gc_count); end
`else
        n_tests++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL gc_ack: got %b expected 0", ack); end
        n_tests++;
        if (gc_count != 0 || wr_q.size() != 0) begin
            n_fail++; $display("FAIL gc_quiet: gc=%0d writes=%0d expected 0/0", gc_count, wr_q.size());
        end
`endif
        host_addr = 4'd1; #1;
        n_tests++;
        if (host_rdata !== mem[1]) begin n_fail++; $display("FAIL gc_reg1: got %h expected %h", host_rdata, mem[1]); end
    endtask

    task automatic test_reset_mid_ack();
        logic r, ack, bz;
        bit got;
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(((SADDR << 1) >> i) & 1, r);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (sda_oe) got = 1;
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL rst_ack_drive: got sda_oe=0 expected 1 before reset"); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_async_release: got %b expected 0", sda_oe); end
        master_low = 1'b0; scl = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(4);
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        mptr = 0;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        for (int i = 0; i < DEPTH; i++) begin
            host_addr = 4'(i); #1;
            n_tests++;
            if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_reg[%0d]: got %h expected 00", i, host_rdata); end
        end
        mem[0] = 8'h3C;
        host_write(4'd0, 8'h3C);
        model_read(0, 8'h00, 1);
        read_txn(0, 8'h00, 1, ack, bz);
        n_tests++;
        if (ack !== 1'b1 || rbuf[0] !== expb[0]) begin
            n_fail++; $display("FAIL rst_ptr_zero: ack=%b byte=%h expected 1/%h", ack, rbuf[0], expb[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        tick(5);
        test_reset();
        rst = 1'b0;
        tick(5);
        test_basic_write();
        test_repeated_start_read();
        test_wrap();
        test_nomatch();
        test_host();
        test_random();
        test_host_during_read();
        test_collision();
        test_general_call();
        test_reset_mid_ack();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

Parametrised, synthesizable I2C slave with an internal byte-wide register file, auto-incrementing register pointer, repeated-start support and a host-side access port. Successor to the fixed-address, single-byte slave model in the FPGA_I2C bench, and drop-in target for the FPGA_I2C master. It sits on the SCL/SDA pins through an open-drain pad and exposes received bytes and register contents to on-chip logic.

## Interface
- ADDRESS, 7'h26, 7-bit slave address
- DEPTH, 16, number of 8-bit registers (power of two, 2..256); PTR_W = clog2(DEPTH)
- SYNC_STAGES, 2, synchroniser flops on SCL and SDA (≥2)

- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- SCL  in  1  bus clock from pad (slave never stretches)
- SDA_IN  in  1  bus data from pad
- SDA_OE  out  1  1 = pull SDA low; 0 = release
- host_we  in  1  host write strobe
- host_addr  in  PTR_W  host register address
- host_wdata  in  8  host write data
- host_rdata  out  8  regs[host_addr], combinational read
- wr_valid  out  1  one-CLK pulse: I2C master wrote a register
- wr_addr  out  PTR_W  register written (valid with wr_valid)
- wr_data  out  8  byte written (valid with wr_valid)
- busy  out  1  high from addressed start until stop/NACK/non-match
- gc_hit  out  1  one-CLK pulse on acked general-call address

## Operation
- Bus sampling: SCL/SDA pass SYNC_STAGES flops; edges derived from last two synced samples. START = SDA fall while SCL high; STOP = SDA rise while SCL high. Data sampled on synced SCL rise; SDA_OE updated on synced SCL fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- START from any state -> ADDR, bit counter cleared (repeated start). STOP from any state -> IDLE, SDA_OE=0, busy=0.
- ADDR: shift 8 bits MSB first. Match (addr==ADDRESS) -> ADDR_ACK, busy=1; else -> IGNORE (no ACK, SDA never driven until next START).
- ADDR_ACK: drive SDA low for the 9th clock. R/W=0 -> PTR; R/W=1 -> load shift reg with regs[ptr], -> RDATA.
- PTR: byte received -> ptr := byte mod DEPTH (low PTR_W bits), ACK in PTR_ACK, -> WDATA.
- WDATA: byte received -> regs[ptr] := byte, wr_valid pulse with wr_addr=ptr, ptr := ptr+1 wrapping DEPTH-1 -> 0; ACK in WDATA_ACK; -> WDATA.
- RDATA: drive MSB first (SDA_OE = ~bit); after 8 bits release SDA, ptr := ptr+1 (wrap), -> RACK.
- RACK: sample master bit on 9th SCL rise. 0 (ACK) -> load regs[ptr], -> RDATA. 1 (NACK) -> IGNORE, busy=0.
- ptr retained across transactions; read without preceding pointer write continues from last ptr.
- Host port: host_we writes regs[host_addr] on CLK edge. Same-cycle host and I2C write to same register: I2C write wins. Read byte is latched into shift reg at load; host writes during transmission do not alter the byte on the wire.

## Timing
- Reset: SDA_OE=0, wr_valid=0, busy=0, gc_hit=0, wr_addr=0, wr_data=0, ptr=0, all regs=0, state IDLE, synchronisers=1. SDA released immediately on RST assertion (asynchronous), including mid-byte.
- Pin-to-detect latency: SYNC_STAGES+1 CLK. SCL high and low phases must each be ≥ SYNC_STAGES+3 CLK; SDA setup/hold per I2C standard mode satisfied at 100 kHz with CLK ≥ 2 MHz.
- SDA_OE changes at most SYNC_STAGES+2 CLK after pin SCL fall (inside SCL low).
- wr_valid asserted on the CLK after the 8th data-bit SCL rise is detected, exactly one CLK.
- host_rdata: zero-cycle combinational; reflects host/I2C writes the CLK after they occur.

## Configuration
- I2C_GENERAL_CALL_EN defined: address 7'h00 with R/W=0 is acked, gc_hit pulses one CLK at ACK drive, then handled identically to an own-address write (pointer byte, data bytes). 7'h00 with R/W=1 -> IGNORE.
- Undefined: 7'h00 treated as non-match (IGNORE, no ACK); gc_hit tied 0.

## Structure
- Package i2c_pkg: state enum, I2C_RW_READ/I2C_RW_WRITE, ADDR_BITS=7, BYTE_BITS=8, GENERAL_CALL_ADDR=7'h00.
- Sub-module i2c_bus_sync: SYNC_STAGES synchronisers, SCL rise/fall and START/STOP detection, outputs one-CLK pulses.
- Register file inferred as flops/distributed RAM in top.

## Test plan
- Write 0x26+W, ptr 0x03, data 0xA5, 0x5A, STOP -> ACK on all 4 bytes; wr_valid twice (addr 3 data 0xA5, addr 4 data 0x5A); host_rdata@3=0xA5.
- Write ptr 0x02, repeated START, 0x26+R, master ACK, ACK, NACK -> bytes regs[2],regs[3],regs[4] on wire; ptr ends 5; busy falls at NACK.
- DEPTH=16, ptr 0x0F, write 3 bytes -> registers 15, 0, 1 written (wrap).
- Address 0x27+W -> SDA_OE never asserts until next START; busy stays 0; no wr_valid.
- RST asserted while slave drives ACK low -> SDA_OE=0 same cycle; after release all regs 0, state IDLE.
- With I2C_GENERAL_CALL_EN: 0x00+W, ptr 1, data 0x77 -> ACK, gc_hit one pulse, reg1=0x77; without macro -> no ACK.
